// File: rtl/bip_mem_responder.sv
// bip_mem_responder: program/data memory responder for the BIP accumulator CPU.
// Sequences bring-up (optional DM clear, program load, CPU release) and detects
// HALT (opcode 0). Optional feature macro: BIP_MEM_DM_CLEAR_EN enables the CLEAR
// state that zeroes data memory after reset and after restart.
module bip_mem_responder #(
  parameter int unsigned PM_AW = 6,
  parameter int unsigned DM_AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        restart,
  output logic        cpu_reset,
  input  logic [10:0] addr_to_pm,
  output logic [15:0] instruction,
  input  logic [10:0] addr_to_dm,
  input  logic [15:0] data_to_dm,
  input  logic        RdRam,
  input  logic        WrRam,
  output logic [15:0] data_from_dm,
  output logic        halted,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_HALTED} state_e;

`ifdef BIP_MEM_DM_CLEAR_EN
  localparam state_e START_S = S_CLEAR;
`else
  localparam state_e START_S = S_LOAD;
`endif

  state_e             state_q;
  logic [PM_AW-1:0]   load_ptr_q;
`ifdef BIP_MEM_DM_CLEAR_EN
  logic [DM_AW-1:0]   clr_ptr_q;
`endif
  logic [15:0]        cyc_q;
  logic               halted_q;
  logic               cpu_reset_q;

  logic [15:0]        pm_q [0:(1<<PM_AW)-1];
  logic [15:0]        dm_q [0:(1<<DM_AW)-1];

  logic [PM_AW-1:0]   pm_a;
  logic [DM_AW-1:0]   dm_a;
  logic [15:0]        pm_rd;
  logic               serve;
  logic               load_hs;
  logic               unused_addr_hi;

  assign pm_a           = addr_to_pm[PM_AW-1:0];
  assign dm_a           = addr_to_dm[DM_AW-1:0];
  assign pm_rd          = pm_q[pm_a];
  assign serve          = (state_q == S_RUN) || (state_q == S_HALTED);
  // Gated with reset so load_ready reads 0 while reset is held, even when the
  // block resets straight into LOAD.
  assign load_ready     = reset && (state_q == S_LOAD);
  assign load_hs        = load_valid && load_ready;
  assign unused_addr_hi = ^{addr_to_pm[10:PM_AW], addr_to_dm[10:DM_AW]};

  assign instruction  = serve ? pm_rd : '0;
  assign data_from_dm = (serve && RdRam) ? dm_q[dm_a] : '0;
  assign cpu_reset    = cpu_reset_q;
  assign halted       = halted_q;
  assign cycle_count  = cyc_q;

  // Bring-up / run / halt sequencer with registered CPU-facing status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= START_S;
      load_ptr_q  <= '0;
`ifdef BIP_MEM_DM_CLEAR_EN
      clr_ptr_q   <= '0;
`endif
      cyc_q       <= '0;
      halted_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      case (state_q)
`ifdef BIP_MEM_DM_CLEAR_EN
        S_CLEAR: begin
          cyc_q     <= '0;
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == '1) state_q <= S_LOAD;
        end
`endif
        S_LOAD: begin
          cyc_q <= '0;
          if (load_hs) begin
            load_ptr_q <= load_ptr_q + 1'b1;
            if (load_last || (load_ptr_q == '1)) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          if (pm_rd[15:11] == 5'd0) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          // Counter is cleared on the way out so it already reads 0 in the
          // first cycle of the new bring-up.
          if (restart) begin
            state_q     <= START_S;
            halted_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            load_ptr_q  <= '0;
            cyc_q       <= '0;
`ifdef BIP_MEM_DM_CLEAR_EN
            clr_ptr_q   <= '0;
`endif
          end
        end
        default: begin
          state_q     <= START_S;
          cpu_reset_q <= 1'b1;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  // Program memory: written only by accepted load handshakes, retained across reset.
  always_ff @(posedge clk) begin
    if (load_hs) pm_q[load_ptr_q] <= load_data;
  end

  // Data memory: zeroed by CLEAR when present, otherwise written by the CPU in RUN.
  always_ff @(posedge clk) begin
`ifdef BIP_MEM_DM_CLEAR_EN
    if (state_q == S_CLEAR) dm_q[clr_ptr_q] <= '0;
    else
`endif
    if ((state_q == S_RUN) && WrRam) dm_q[dm_a] <= data_to_dm;
  end

endmodule

// File: tb/tb_bip_mem_responder.sv
// Scoreboard bench for bip_mem_responder: stimulus queues expected output
// values per cycle, a negedge monitor pops and compares them.
module tb_bip_mem_responder;

`ifdef BIP_MEM_DM_CLEAR_EN
  localparam int CLR = 64;
`else
  localparam int CLR = 0;
`endif

  localparam int S_LR = 0, S_CR = 1, S_HA = 2, S_CC = 3, S_IN = 4, S_DD = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_last, restart, RdRam, WrRam;
  logic [15:0] load_data, data_to_dm;
  logic [10:0] addr_to_pm, addr_to_dm;
  logic        load_ready, cpu_reset, halted;
  logic [15:0] instruction, data_from_dm, cycle_count;

  bip_mem_responder #(.PM_AW(6), .DM_AW(6)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .restart(restart), .cpu_reset(cpu_reset),
    .addr_to_pm(addr_to_pm), .instruction(instruction),
    .addr_to_dm(addr_to_dm), .data_to_dm(data_to_dm),
    .RdRam(RdRam), .WrRam(WrRam), .data_from_dm(data_from_dm),
    .halted(halted), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int          q_cyc[$];
  int          q_sel[$];
  logic [15:0] q_exp[$];
  string       q_name[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic exp_o(input int sel, input logic [15:0] e, input string nm);
    q_cyc.push_back(tb_cyc);
    q_sel.push_back(sel);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      S_LR:    return {15'd0, load_ready};
      S_CR:    return {15'd0, cpu_reset};
      S_HA:    return {15'd0, halted};
      S_CC:    return cycle_count;
      S_IN:    return instruction;
      default: return data_from_dm;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    int          c, s;
    logic [15:0] e, a;
    string       nm;
    while (q_cyc.size() > 0 && q_cyc[0] <= tb_cyc) begin
      c  = q_cyc.pop_front();
      s  = q_sel.pop_front();
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      a  = actual(s);
      n_vec++;
      if (c < tb_cyc) begin
        n_err++;
        $display("FAIL %s: checked late at cycle %0d (due %0d), got %h want %h", nm, tb_cyc, c, a, e);
      end else if (a !== e) begin
        n_err++;
        $display("FAIL %s: cycle %0d got %h want %h", nm, tb_cyc, a, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] prog [4];

  initial begin
    prog[0] = 16'h180A; prog[1] = 16'h3806; prog[2] = 16'h0802; prog[3] = 16'h0000;
    reset = 1'b1; load_valid = 0; load_last = 0; restart = 0; RdRam = 0; WrRam = 0;
    load_data = '0; data_to_dm = '0; addr_to_pm = '0; addr_to_dm = '0;
    #2 reset = 1'b0;
    step();
    RdRam = 1'b1;
    exp_o(S_LR, 0, "rst_load_ready");
    exp_o(S_CR, 1, "rst_cpu_reset");
    exp_o(S_HA, 0, "rst_halted");
    exp_o(S_CC, 0, "rst_cycle_count");
    exp_o(S_IN, 0, "rst_instruction");
    exp_o(S_DD, 0, "rst_data_from_dm");
    step();
    RdRam = 1'b0;
    reset = 1'b1;
    exp_o(S_LR, (CLR > 0) ? 16'd0 : 16'd1, "lr_cycle0");
    if (CLR > 0) begin
      repeat (CLR - 1) step();
      exp_o(S_LR, 0, "lr_cycle63");
      step();
      exp_o(S_LR, 1, "lr_cycle64");
    end

    // Program load and release.
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
      exp_o(S_LR, 1, "load_ready_in_load");
      exp_o(S_CR, 1, "cpu_reset_in_load");
      step();
    end
    load_valid = 0; load_last = 0;

    // RUN c0: write 4 to addr 2
    exp_o(S_CR, 0, "cpu_reset_released");
    exp_o(S_LR, 0, "lr_in_run");
    addr_to_pm = 11'd0; WrRam = 1; RdRam = 0; addr_to_dm = 11'd2; data_to_dm = 16'h0004;
    exp_o(S_IN, 16'h180A, "pm0");
    exp_o(S_DD, 16'h0000, "dm_no_rd");
    exp_o(S_CC, 0, "cc_run0");
    step();
    // c1: read back
    addr_to_pm = 11'd1; WrRam = 0; RdRam = 1; addr_to_dm = 11'd2;
    exp_o(S_IN, 16'h3806, "pm1");
    exp_o(S_DD, 16'h0004, "dm_rd_after_wr");
    exp_o(S_CC, 1, "cc_run1");
    step();
    // c2: aliased address, simultaneous read/write
    addr_to_pm = 11'd2; WrRam = 1; RdRam = 1; addr_to_dm = 11'h042; data_to_dm = 16'h0009;
    exp_o(S_IN, 16'h0802, "pm2");
    exp_o(S_DD, 16'h0004, "dm_alias_rw_old");
    exp_o(S_CC, 2, "cc_run2");
    step();
    // c3: HALT presented
    addr_to_pm = 11'd3; WrRam = 0; RdRam = 1; addr_to_dm = 11'd2;
    exp_o(S_IN, 16'h0000, "pm3_halt");
    exp_o(S_DD, 16'h0009, "dm_rw_new");
    exp_o(S_CC, 3, "cc_run3");
    exp_o(S_HA, 0, "halted_not_yet");
    step();
    // HALTED h0: write must be ignored
    addr_to_pm = 11'd1; WrRam = 1; RdRam = 1; addr_to_dm = 11'd2; data_to_dm = 16'h00FF;
    exp_o(S_HA, 1, "halted_set");
    exp_o(S_CC, 4, "cc_at_halt");
    exp_o(S_CR, 0, "cpu_reset_halted");
    exp_o(S_IN, 16'h3806, "pm_in_halted");
    exp_o(S_DD, 16'h0009, "dm_in_halted");
    step();
    WrRam = 0; restart = 1;
    exp_o(S_DD, 16'h0009, "dm_wr_ignored_halted");
    exp_o(S_CC, 4, "cc_frozen");
    step();
    // Restarted
    restart = 0;
    exp_o(S_HA, 0, "halted_cleared");
    exp_o(S_CC, 0, "cc_cleared_restart");
    exp_o(S_CR, 1, "cpu_reset_restart");
    exp_o(S_IN, 0, "instr_zero_bringup");
    exp_o(S_DD, 0, "dm_zero_bringup");
    exp_o(S_LR, (CLR > 0) ? 16'd0 : 16'd1, "lr_restart0");
    if (CLR > 0) begin
      repeat (CLR - 1) step();
      exp_o(S_LR, 0, "lr_restart63");
      step();
      exp_o(S_LR, 1, "lr_restart64");
    end
    RdRam = 0; addr_to_pm = 11'd0;

    // Overflow load: 64 words, no load_last.
    for (int i = 0; i < 64; i++) begin
      load_valid = 1; load_data = 16'h0800 | 16'(i); load_last = 0;
      exp_o(S_LR, 1, "lr_overflow_load");
      step();
    end
    load_data = 16'hFFFF;
    exp_o(S_LR, 0, "lr_after_64");
    exp_o(S_CR, 0, "cpu_reset_after_64");
    exp_o(S_CC, 0, "cc_run_start");
    exp_o(S_IN, 16'h0800, "pm0_after_64");
    step();
    load_valid = 0;
    for (int i = 0; i < 64; i++) begin
      addr_to_pm = 11'h040 | 11'(i); RdRam = 1; addr_to_dm = 11'(i);
      exp_o(S_IN, 16'h0800 | 16'(i), "pm_alias_scan");
`ifdef BIP_MEM_DM_CLEAR_EN
      exp_o(S_DD, 16'h0000, "dm_cleared_scan");
`else
      if (i == 2) exp_o(S_DD, 16'h0009, "dm_kept_after_restart");
`endif
      exp_o(S_CC, 16'(i + 1), "cc_scan");
      step();
    end
    RdRam = 0; addr_to_pm = 11'd0;

    // Mid-operation reset.
    reset = 0;
    #1;
    exp_o(S_LR, 0, "midrst_lr");
    exp_o(S_CR, 1, "midrst_cpu_reset");
    exp_o(S_HA, 0, "midrst_halted");
    exp_o(S_CC, 0, "midrst_cc");
    exp_o(S_IN, 0, "midrst_instr");
    step();
    reset = 1;
    repeat (CLR) step();
    load_valid = 1; load_data = 16'h2001; step();
    load_data = 16'h2002; step();
    load_valid = 0;
    reset = 0;
    #1;
    exp_o(S_LR, 0, "partial_rst_lr");
    exp_o(S_CR, 1, "partial_rst_cpu_reset");
    step();
    reset = 1;
    repeat (CLR) step();
    exp_o(S_LR, 1, "reload_ready");
    load_valid = 1; load_data = 16'h3003; load_last = 1;
    step();
    load_valid = 0; load_last = 0;
    addr_to_pm = 11'd0;
    exp_o(S_CR, 0, "reload_released");
    exp_o(S_IN, 16'h3003, "reload_ptr_from0");
    step();
    addr_to_pm = 11'd1;
    exp_o(S_IN, 16'h2002, "pm_retained1");
    step();
    addr_to_pm = 11'd5;
    exp_o(S_IN, 16'h0805, "pm_retained5");
    step();
    step();
    while (q_cyc.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unchecked %s: due cycle %0d never compared", q_name[0], q_cyc[0]);
      void'(q_cyc.pop_front()); void'(q_sel.pop_front());
      void'(q_exp.pop_front()); void'(q_name.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
